ps2_key_event_ctrl: RTL

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_event_fifo.sv | 63 ++++++
 rtl/ps2_key_event_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event controller: sequence FSM
// states, prefix/status byte values, err_flags bit positions and event width.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_KERR0   = 8'h00;
    localparam logic [7:0] PS2_KERR1   = 8'hFF;

    localparam int ERR_OVF = 0;
    localparam int ERR_TMO = 1;
    localparam int ERR_RXE = 2;

    // Event word layout: {code[7:0], ext, break}
    localparam int EV_W = 10;

    function automatic logic is_status_discard(input logic [7:0] b);
        return (b == PS2_KERR0) || (b == PS2_ECHO) || (b == PS2_ACK) ||
               (b == PS2_RESEND) || (b == PS2_KERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a full FIFO accepts a push only when
// the head is popped in the same cycle, otherwise the push is reported as overflow.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    // Pop is gated by !empty, so push+pop on an empty FIFO is a plain enqueue.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_overflow = i_push && w_full && !w_do_pop;
    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: decodes E0/F0 prefixes into key events queued in a
// FIFO. Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeated makes of a held key.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       bat_ok,
    output logic [2:0] err_flags,
    input  logic       err_clr,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e      r_state;
    ps2_state_e      w_state_nxt;
    logic [CW-1:0]   r_tmo_cnt;
    logic            r_bat_ok;
    logic [2:0]      r_err;

    logic            w_byte;
    logic            w_timeout;
    logic            w_tmo_fire;
    logic            w_dec_push;
    logic            w_dec_ext;
    logic            w_dec_brk;
    logic            w_bat_set;
    logic            w_push;
    logic            w_ovf;
    logic [EV_W-1:0] w_fifo_dout;
    logic [2:0]      w_err_set;

    // A strobe with rx_err set carries a corrupt byte and is never decoded.
    assign w_byte     = rx_valid && !rx_err;
    assign w_timeout  = (r_state != ST_IDLE) && (r_tmo_cnt == CW'(TIMEOUT_CYCLES));
    assign w_tmo_fire = w_timeout && !rx_valid && !rx_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (rx_err) begin
            w_state_nxt = ST_IDLE;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == PS2_PFX_EXT)      w_state_nxt = ST_E0;
                    else if (rx_data == PS2_PFX_BRK) w_state_nxt = ST_F0;
                    else                             w_state_nxt = ST_IDLE;
                end
                ST_E0: begin
                    if (rx_data == PS2_PFX_BRK)      w_state_nxt = ST_E0F0;
                    else if (rx_data == PS2_PFX_EXT) w_state_nxt = ST_E0;
                    else                             w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_dec_push = 1'b0;
        w_dec_ext  = 1'b0;
        w_dec_brk  = 1'b0;
        w_bat_set  = 1'b0;
        if (w_byte) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == PS2_BAT_OK) begin
                        w_bat_set = 1'b1;
                    end else if ((rx_data != PS2_PFX_EXT) && (rx_data != PS2_PFX_BRK) &&
                                 !is_status_discard(rx_data)) begin
                        w_dec_push = 1'b1;
                    end
                end
                ST_E0: begin
                    if ((rx_data != PS2_PFX_EXT) && (rx_data != PS2_PFX_BRK)) begin
                        w_dec_push = 1'b1;
                        w_dec_ext  = 1'b1;
                    end
                end
                ST_F0: begin
                    w_dec_push = 1'b1;
                    w_dec_brk  = 1'b1;
                end
                default: begin
                    w_dec_push = 1'b1;
                    w_dec_ext  = 1'b1;
                    w_dec_brk  = 1'b1;
                end
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] r_last_code;
    logic       r_last_ext;
    logic       r_held;
    logic       w_same_key;

    assign w_same_key = (rx_data == r_last_code) && (w_dec_ext == r_last_ext);
    assign w_push     = w_dec_push && !(!w_dec_brk && r_held && w_same_key);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_code <= '0;
            r_last_ext  <= 1'b0;
            r_held      <= 1'b0;
        end else if (w_dec_push) begin
            if (!w_dec_brk) begin
                r_last_code <= rx_data;
                r_last_ext  <= w_dec_ext;
                r_held      <= 1'b1;
            end else if (w_same_key) begin
                r_held      <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_dec_push;
`endif

    // Counter idles at zero in IDLE and restarts on every received strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (rx_valid || rx_err || (r_state == ST_IDLE) || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_err_set = {rx_err, w_tmo_fire, w_ovf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err    <= '0;
            r_bat_ok <= 1'b0;
        end else begin
            r_err    <= (err_clr ? 3'b000 : r_err) | w_err_set;
            r_bat_ok <= w_bat_set;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_data     ({rx_data, w_dec_ext, w_dec_brk}),
        .i_pop      (ev_ready),
        .o_valid    (ev_valid),
        .o_data     (w_fifo_dout),
        .o_overflow (w_ovf)
    );

    assign ev_code   = w_fifo_dout[9:2];
    assign ev_ext    = w_fifo_dout[1];
    assign ev_break  = w_fifo_dout[0];
    assign bat_ok    = r_bat_ok;
    assign err_flags = r_err;
    assign dbg_state = r_state;

endmodule
